muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multi-cycle integer multiply/divide unit implementing the RV M-extension ops, selected by funct3. It sits beside the combinational ALU in the execute stage. The pipeline issues through a valid/ready request channel and retires through a valid/ready response channel carrying a destination tag. Computes radix-2, one bit per cycle, with width parametrised for RV32/RV64.

Parameters:
Width, 32, operand/result width in bits; legal values are 32 and 64.
TagWidth, 5, width of the opaque tag passed from request to response (typically rd index).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
valid_i  input  1  request valid
ready_o  output  1  unit can accept a request
funct3_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  input  Width  operand rs1
b_i  input  Width  operand rs2
tag_i  input  TagWidth  request tag
flush_i  input  1  abort any in-flight or pending op
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
res_o  output  Width  result
tag_o  output  TagWidth  tag of the result

Behaviour:
- States: Idle, Busy, Done. Reset puts the unit in Idle. Reset values: ready_o=1, valid_o=0, res_o=0, tag_o=0, iteration counter=0.
- ready_o = (state==Idle). Accept happens on an edge where valid_i && ready_o && !flush_i. On accept, latch funct3, operands, and tag; go to Busy with counter=Width.
- Busy runs for exactly Width cycles and processes one bit per cycle:
  - Multiply: shift-add on absolute values. Signedness: MULH both signed, MULHSU a signed/b unsigned, MULHU both unsigned. The product is held in a 2*Width register and negated at the end if the sign requires.
  - Divide: restoring shift-subtract on absolute values. Quotient sign is sign(a)^sign(b). Remainder takes the sign of the dividend.
- When the counter reaches 0, go to Done. res_o and tag_o are registered and stable for the whole of Done.
- Result selection: MUL gives the low Width bits; MULH, MULHSU and MULHU give the high Width bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
- Latency: if the accept is in cycle 0, valid_o is first high in cycle Width+1. Throughput is one op per Width+2 cycles minimum; ready_o is not asserted during Done.
- Done: hold valid_o=1, res_o, and tag_o until ready_i=1, then go to Idle on that edge.
- Division by zero: quotient is all ones; remainder equals the dividend a.
- Signed overflow (DIV/REM of most-negative by -1): quotient is most-negative, remainder is 0.
- These two cases take the same latency as normal ops unless the optional feature is enabled.
- flush_i has priority over every other event:
  - In any state, go to Idle on the next edge with valid_o=0.
  - A request presented with flush_i=1 is not accepted.
  - A Done result being flushed is dropped even if ready_i=1.
- Reset mid-operation: the unit is in Idle immediately (asynchronous). The in-flight op is lost and no valid_o is produced for it.
- Operands are sampled only on accept; changes to a_i, b_i, and tag_i while Busy have no effect.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: an accepted op goes straight from Idle to Done, with valid_o high in cycle 1, in these cases:
  - divide by zero;
  - signed overflow;
  - multiply with either operand zero (result 0).
  Results are identical to the full computation.
- Undefined: every op takes the fixed Width+1 latency.

Test Plan:
1. Width=32, MUL a=7, b=0xFFFFFFFD, accept cycle 0 -> valid_o first high in cycle 33, res_o=0xFFFFFFEB, tag_o=request tag.
2. Multiply-high ops, each -> valid_o in cycle 33:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide ops:
   - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
   - REMU same operands -> 1.
4. Corner cases:
   - DIV 5/0 -> 0xFFFFFFFF.
   - REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM same operands -> 0.
   - Latency is 33 without MULDIV_EARLY_OUT_EN and 1 with it.
5. Backpressure: hold ready_i=0 for 4 cycles after valid_o rises -> res_o and tag_o stable, ready_o=0, a new valid_i is ignored. Raise ready_i -> Idle, and the next request is accepted one cycle later.
6. Abort cases:
   - flush_i in Busy cycle 10 -> ready_o=1 next cycle, no valid_o for that tag.
   - rst_i asserted mid-Busy -> outputs return to reset values immediately; the next op completes correctly.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response channel between the execute stage and muldiv_unit.
// Suffixes follow the unit's view: _i into the unit, _o out of it.
interface muldiv_unit_if #(
    parameter int Width    = 32,
    parameter int TagWidth = 5
);
    logic                valid_i;
    logic                ready_o;
    logic [2:0]          funct3_i;
    logic [Width-1:0]    a_i;
    logic [Width-1:0]    b_i;
    logic [TagWidth-1:0] tag_i;
    logic                flush_i;
    logic                valid_o;
    logic                ready_i;
    logic [Width-1:0]    res_o;
    logic [TagWidth-1:0] tag_o;

    modport master (
        output valid_i, funct3_i, a_i, b_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, res_o, tag_o
    );

    modport slave (
        input  valid_i, funct3_i, a_i, b_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, res_o, tag_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV M-extension multiply/divide unit.
// Define MULDIV_EARLY_OUT_EN to finish trivial ops (div by 0, overflow, mul by 0) in one cycle.
module muldiv_unit #(
    parameter int Width    = 32,
    parameter int TagWidth = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    muldiv_unit_if.slave bus
);
    localparam int CntW = $clog2(Width + 1);

    typedef enum logic [1:0] {Idle, Busy, Done} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic [Width-1:0]    opx_q, opx_d;
    logic [2*Width-1:0]  acc_q, acc_d;
    logic [Width-1:0]    res_q, res_d;
    logic [TagWidth-1:0] tag_q, tag_d;

    logic                is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [Width-1:0]    abs_a, abs_b;

    assign is_div = bus.funct3_i[2];

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (bus.funct3_i)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'd2:    sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign neg_a = sgn_a & bus.a_i[Width-1];
    assign neg_b = sgn_b & bus.b_i[Width-1];
    assign abs_a = neg_a ? -bus.a_i : bus.a_i;
    assign abs_b = neg_b ? -bus.b_i : bus.b_i;

    // acc holds {hi, lo}: product accumulator for mul, {remainder, quotient} for div
    logic [Width:0]       msum, dshf, ddif;
    logic [2*Width-1:0]   step, prod;
    logic [Width-1:0]     quo, rem, fin;

    assign msum = {1'b0, acc_q[2*Width-1:Width]}
                + {1'b0, acc_q[0] ? opx_q : {Width{1'b0}}};
    assign dshf = acc_q[2*Width-1:Width-1];
    assign ddif = dshf - {1'b0, opx_q};

    always_comb begin
        if (op_q[2]) begin
            if (ddif[Width])
                step = {dshf[Width-1:0], acc_q[Width-2:0], 1'b0};
            else
                step = {ddif[Width-1:0], acc_q[Width-2:0], 1'b1};
        end else begin
            step = {msum, acc_q[Width-1:1]};
        end
    end

    // a zero divisor must keep the all-ones quotient, so skip the sign fix-up
    assign prod = (sa_q ^ sb_q) ? -step : step;
    assign quo  = ((sa_q ^ sb_q) && !bz_q) ? -step[Width-1:0] : step[Width-1:0];
    assign rem  = sa_q ? -step[2*Width-1:Width] : step[2*Width-1:Width];

    always_comb begin
        unique case (op_q)
            3'd0:             fin = prod[Width-1:0];
            3'd1, 3'd2, 3'd3: fin = prod[2*Width-1:Width];
            3'd4, 3'd5:       fin = quo;
            default:          fin = rem;
        endcase
    end

    logic             early;
    logic [Width-1:0] eres;
`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        early = 1'b0;
        eres  = '0;
        if (is_div) begin
            if (bus.b_i == '0) begin
                early = 1'b1;
                eres  = bus.funct3_i[1] ? bus.a_i : '1;
            end else if (sgn_a && (&bus.b_i)
                         && bus.a_i == {1'b1, {(Width-1){1'b0}}}) begin
                early = 1'b1;
                eres  = bus.funct3_i[1] ? '0 : bus.a_i;
            end
        end else if (bus.a_i == '0 || bus.b_i == '0) begin
            early = 1'b1;
        end
    end
`else
    assign early = 1'b0;
    assign eres  = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        opx_d   = opx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (bus.flush_i) begin
            state_d = Idle;
        end else begin
            unique case (state_q)
                Idle: if (bus.valid_i) begin
                    op_d  = bus.funct3_i;
                    sa_d  = neg_a;
                    sb_d  = neg_b;
                    bz_d  = (bus.b_i == '0);
                    tag_d = bus.tag_i;
                    opx_d = is_div ? abs_b : abs_a;
                    acc_d = {{Width{1'b0}}, is_div ? abs_a : abs_b};
                    if (early) begin
                        state_d = Done;
                        res_d   = eres;
                    end else begin
                        state_d = Busy;
                        cnt_d   = CntW'(Width);
                    end
                end
                Busy: begin
                    acc_d = step;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = Done;
                        res_d   = fin;
                    end
                end
                Done: if (bus.ready_i) state_d = Idle;
                default: state_d = Idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            opx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            opx_q   <= opx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.ready_o = (state_q == Idle);
    assign bus.valid_o = (state_q == Done);
    assign bus.res_o   = res_q;
    assign bus.tag_o   = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, aborts,
// backpressure and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int TW = 5;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.Width(W), .TagWidth(TW)) bus ();
    muldiv_unit #(.Width(W), .TagWidth(TW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
    } vec_t;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        if (f[2]) begin
            if (b == '0) return f[1] ? a : '1;
            if (!f[0] && a == MINV && b == '1) return f[1] ? '0 : MINV;
            case (f[1:0])
                2'd0:    p = sa / sb;
                2'd1:    p = ua / ub;
                2'd2:    p = sa % sb;
                default: p = ua % ub;
            endcase
            return p[W-1:0];
        end
        case (f[1:0])
            2'd2:    p = sa * ub;
            2'd3:    p = ua * ub;
            default: p = sa * sb;
        endcase
        return (f[1:0] == 2'd0) ? p[W-1:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        bit early;
        if (f[2]) early = (b == '0) || (!f[0] && a == MINV && b == '1);
        else      early = (a == '0) || (b == '0);
        return (early && EarlyEn) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic start(input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t);
        bus.valid_i  = 1'b1;
        bus.funct3_i = f;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.tag_i    = t;
        @(posedge clk); #1;
        bus.valid_i  = 1'b0;
        bus.a_i      = W'($urandom);
        bus.b_i      = W'($urandom);
        bus.tag_i    = TW'($urandom);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t, input logic [W-1:0] e);
        int lat;
        chk({nm, ".rdy"}, 32'(bus.ready_o), 1);
        start(f, a, b, t);
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 3 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(exp_lat(f, a, b)));
        chk({nm, ".res"}, bus.res_o, e);
        chk({nm, ".tag"}, 32'(bus.tag_o), 32'(t));
    endtask

    task automatic retire(input string nm, input int hold,
                          input logic [W-1:0] e, input logic [TW-1:0] t);
        repeat (hold) begin
            bus.valid_i  = 1'b1;
            bus.funct3_i = 3'($urandom);
            bus.a_i      = W'($urandom);
            bus.b_i      = W'($urandom);
            bus.tag_i    = TW'($urandom);
            @(posedge clk); #1;
            chk({nm, ".hv"}, 32'(bus.valid_o), 1);
            chk({nm, ".hr"}, 32'(bus.ready_o), 0);
            chk({nm, ".hres"}, bus.res_o, e);
            chk({nm, ".htag"}, 32'(bus.tag_o), 32'(t));
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        chk({nm, ".idle"}, 32'(bus.ready_o), 1);
        chk({nm, ".nv"}, 32'(bus.valid_o), 0);
    endtask

    vec_t dir[$];

    initial begin
        logic [2:0]    f;
        logic [W-1:0]  a, b, e;
        logic [TW-1:0] t;
        int            h, seen;

        bus.valid_i  = 1'b0;
        bus.funct3_i = '0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.tag_i    = '0;
        bus.flush_i  = 1'b0;
        bus.ready_i  = 1'b1;
        #1;
        chk("rst.rdy", 32'(bus.ready_o), 1);
        chk("rst.vld", 32'(bus.valid_o), 0);
        chk("rst.res", bus.res_o, 0);
        chk("rst.tag", 32'(bus.tag_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        dir.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
        dir.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        dir.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC});
        dir.push_back('{3'd7, 32'hFFFF_FFF9, 32'd2,         32'd1});
        dir.push_back('{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF});
        dir.push_back('{3'd7, 32'd5,         32'd0,         32'd5});
        dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});
        dir.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF});
        dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        dir.push_back('{3'd0, 32'd0,         32'd12345,     32'd0});

        foreach (dir[i]) begin
            run_op($sformatf("d%0d", i), dir[i].f, dir[i].a, dir[i].b,
                   TW'(i + 3), dir[i].e);
            retire($sformatf("d%0d", i), 0, dir[i].e, TW'(i + 3));
        end

        // backpressure, then back-to-back accept
        bus.ready_i = 1'b0;
        run_op("bp", 3'd0, 32'd1000, 32'd77, 5'd21, 32'd77000);
        retire("bp", 4, 32'd77000, 5'd21);
        run_op("bp2", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        retire("bp2", 0, 32'd14, 5'd9);

        // request presented with flush is refused
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("fl.rej", 32'(bus.ready_o), 1);

        // flush in busy cycle 10
        start(3'd1, 32'd123, 32'd456, 5'd17);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("fl.rdy", 32'(bus.ready_o), 1);
        seen = 0;
        repeat (40) begin
            if (bus.valid_o === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        chk("fl.nv", 32'(seen), 0);

        // flush in done drops the result despite ready_i
        bus.ready_i = 1'b0;
        run_op("fd", 3'd6, 32'd100, 32'd7, 5'd4, 32'd2);
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("fd.nv", 32'(bus.valid_o), 0);
        chk("fd.rdy", 32'(bus.ready_o), 1);

        // asynchronous reset mid-busy
        start(3'd4, 32'd1000, 32'd3, 5'd30);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        chk("ar.rdy", 32'(bus.ready_o), 1);
        chk("ar.vld", 32'(bus.valid_o), 0);
        chk("ar.res", bus.res_o, 0);
        chk("ar.tag", 32'(bus.tag_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("ar2", 3'd4, 32'd1000, 32'd3, 5'd11, 32'd333);
        retire("ar2", 0, 32'd333, 5'd11);

        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            t = TW'($urandom);
            e = model(f, a, b);
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (h > 0) bus.ready_i = 1'b0;
            run_op($sformatf("r%0d", n), f, a, b, t, e);
            retire($sformatf("r%0d", n), h, e, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
